// File: rtl/clkdiv_pkg.sv
// ---------------------------------------------------------------------------
// clkdiv_pkg
// Shared types and defaults for the clkdiv frequency-change scheduler.
//   state_t           : scheduler FSM states (IDLE, HOLD, LOAD, LOCK, DONE)
//   FW_DEFAULT        : default FREQ_VAL width
//   RESET_VAL_DEFAULT : divide value the divider starts with after reset
//   MIN_VAL_DEFAULT   : smallest divide value the divider accepts
//   max_int()         : helper used to size the shared phase counter
// ---------------------------------------------------------------------------
package clkdiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        LOAD,
        LOCK,
        DONE
    } state_t;

    localparam int          FW_DEFAULT        = 32;
    localparam logic [31:0] RESET_VAL_DEFAULT = 32'd2;
    localparam logic [31:0] MIN_VAL_DEFAULT   = 32'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clkdiv_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. The search starts at 'ptr' and
// wraps modulo NREQ; the first requester found wins. The pointer register
// itself is owned by the caller.
// Ports:
//   req       [NREQ-1:0] : request vector
//   ptr       [PW-1:0]   : index with highest priority this cycle
//   en                   : when low, no grant is produced
//   grant     [NREQ-1:0] : one-hot grant
//   grant_idx [PW-1:0]   : encoded index of the grant
//   grant_any            : a grant was produced
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            grant_any
);

    // Walk the requesters starting at ptr; the sum carries one extra bit so
    // the wrap test works for NREQ values that are not powers of two.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] cand;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        sum       = '0;
        cand      = '0;
        if (en) begin
            for (int i = 0; i < NREQ; i++) begin
                sum = {1'b0, ptr} + (PW+1)'(i);
                if (sum >= (PW+1)'(NREQ)) begin
                    sum = sum - (PW+1)'(NREQ);
                end
                cand = sum[PW-1:0];
                if (!grant_any && req[cand]) begin
                    grant[cand] = 1'b1;
                    grant_idx   = cand;
                    grant_any   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/clkdiv_sched.sv
// ---------------------------------------------------------------------------
// clkdiv_sched
// Shares one clock divider between NREQ requesters. A granted change is
// applied glitch-safely: hold the divider in reset, load the new value,
// release it, wait for lock, then signal completion.
// Optional build macro: CLKDIV_SCHED_SAME_SKIP_EN -- when defined, a request
// whose value equals the current freq_val skips straight to DONE.
// Ports:
//   clk_in                     : single clock
//   reset                      : asynchronous, active-high reset
//   req_valid [NREQ-1:0]       : per-requester request, held until req_ack
//   req_freq  [NREQ*FW-1:0]    : requester i value at [i*FW +: FW]
//   req_ack   [NREQ-1:0]       : pulse when a request is captured
//   req_done  [NREQ-1:0]       : pulse when the new frequency is stable
//   req_err   [NREQ-1:0]       : pulse with req_ack when value < MIN_VAL
//   freq_val  [FW-1:0]         : FREQ_VAL to the divider
//   div_reset                  : reset to the divider
//   busy                       : high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module clkdiv_sched
    import clkdiv_pkg::*;
#(
    parameter int            NREQ       = 4,
    parameter int            FW         = FW_DEFAULT,
    parameter logic [FW-1:0] RESET_VAL  = FW'(RESET_VAL_DEFAULT),
    parameter logic [FW-1:0] MIN_VAL    = FW'(MIN_VAL_DEFAULT),
    parameter int            SETTLE_CYC = 4,
    parameter int            LOCK_CYC   = 16
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*FW-1:0]   req_freq,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      req_done,
    output logic [NREQ-1:0]      req_err,
    output logic [FW-1:0]        freq_val,
    output logic                 div_reset,
    output logic                 busy
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(max_int(SETTLE_CYC, LOCK_CYC) + 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] LOCK_LOAD   = CW'(LOCK_CYC - 1);

    state_t          state, next_state;
    logic [CW-1:0]   cnt, cnt_next;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   winner;
    logic [FW-1:0]   cap_val;

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   grant_idx;
    logic            grant_any;
    logic [FW-1:0]   grant_val;
    logic            grant_reject;

    logic [NREQ-1:0] ack_d, err_d, done_d;
    logic [FW-1:0]   freq_d;
    logic            div_reset_d, busy_d;

    // The arbiter only looks at requests while idle, so pending requesters
    // simply wait out an ongoing change.
    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .en        (state == IDLE),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign grant_val    = req_freq[int'(grant_idx)*FW +: FW];
    assign grant_reject = (grant_val < MIN_VAL);

    // State register; the phase counter moves with the state.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic. The counter is reloaded on every state entry and
    // counts down to zero. Entering DONE with cnt=1 (skip path) spends one
    // extra DONE cycle so done lands one cycle after ack, never together.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (grant_any && !grant_reject) begin
`ifdef CLKDIV_SCHED_SAME_SKIP_EN
                    if (grant_val == freq_val) begin
                        next_state = DONE;
                        cnt_next   = CW'(1);
                    end else begin
                        next_state = HOLD;
                        cnt_next   = SETTLE_LOAD;
                    end
`else
                    next_state = HOLD;
                    cnt_next   = SETTLE_LOAD;
`endif
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    next_state = LOAD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            LOAD: begin
                next_state = LOCK;
                cnt_next   = LOCK_LOAD;
            end
            LOCK: begin
                if (cnt == '0) begin
                    next_state = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            DONE: begin
                if (cnt == '0) begin
                    next_state = IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output logic: next values for the registered outputs, derived from the
    // upcoming state so each output lines up with the state it belongs to.
    always_comb begin
        ack_d       = '0;
        err_d       = '0;
        done_d      = '0;
        if (state == IDLE && grant_any) begin
            ack_d = grant;
            if (grant_reject) begin
                err_d = grant;
            end
        end
        if (next_state == DONE && cnt_next == '0) begin
            done_d = NREQ'(1) << winner;
        end
        div_reset_d = (next_state == HOLD) || (next_state == LOAD);
        busy_d      = (next_state != IDLE);
        freq_d      = (state == LOAD) ? cap_val : freq_val;
    end

    // Registered outputs plus the captured request and the round-robin
    // pointer. The pointer advances on rejected grants too, so a requester
    // that keeps sending bad values cannot block the others.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            req_ack   <= '0;
            req_err   <= '0;
            req_done  <= '0;
            freq_val  <= RESET_VAL;
            div_reset <= 1'b0;
            busy      <= 1'b0;
            rr_ptr    <= '0;
            winner    <= '0;
            cap_val   <= '0;
        end else begin
            req_ack   <= ack_d;
            req_err   <= err_d;
            req_done  <= done_d;
            freq_val  <= freq_d;
            div_reset <= div_reset_d;
            busy      <= busy_d;
            if (state == IDLE && grant_any) begin
                winner  <= grant_idx;
                cap_val <= grant_val;
                if (grant_idx == PW'(NREQ - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clkdiv_sched.sv
// ---------------------------------------------------------------------------
// tb_clkdiv_sched
// Scoreboard bench for clkdiv_sched. Every request driven pushes its
// expected ack (index, error flag, cycle) and, if accepted, its expected
// done (index, value, cycle); the per-cycle monitor pops and compares them.
// Honours CLKDIV_SCHED_SAME_SKIP_EN for the same-value latency.
// ---------------------------------------------------------------------------
module tb_clkdiv_sched;

    localparam int          NREQ    = 4;
    localparam int          FW      = 32;
    localparam int          LAT     = 22;
    localparam logic [FW-1:0] MIN_V = 32'd2;
    localparam logic [FW-1:0] RST_V = 32'd2;

    logic                 clk_in    = 1'b0;
    logic                 reset     = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*FW-1:0]   req_freq  = '0;
    logic [NREQ-1:0]      req_ack, req_done, req_err;
    logic [FW-1:0]        freq_val;
    logic                 div_reset, busy;

    int cyc        = 0;
    int checks     = 0;
    int errors     = 0;
    int acks_seen  = 0;
    int dones_seen = 0;
    logic [FW-1:0] model_freq = RST_V;

    typedef struct {
        int   idx;
        logic err;
        int   cyc;
    } ack_exp_t;

    typedef struct {
        int            idx;
        logic [FW-1:0] val;
        int            cyc;
    } done_exp_t;

    ack_exp_t  ack_q[$];
    done_exp_t done_q[$];

    clkdiv_sched #(
        .NREQ       (NREQ),
        .FW         (FW),
        .RESET_VAL  (RST_V),
        .MIN_VAL    (MIN_V),
        .SETTLE_CYC (4),
        .LOCK_CYC   (16)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .req_valid (req_valid),
        .req_freq  (req_freq),
        .req_ack   (req_ack),
        .req_done  (req_done),
        .req_err   (req_err),
        .freq_val  (freq_val),
        .div_reset (div_reset),
        .busy      (busy)
    );

    // Free-running clock and a cycle index that steps on every rising edge.
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [NREQ-1:0] onehot(input int i);
        return NREQ'(1) << i;
    endfunction

    task automatic checkOutput(input string tag, input logic [FW-1:0] act,
                               input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, act, exp, cyc);
        end
    endtask

    // Present a request from one requester during the current cycle and
    // record what the DUT should answer. Assumes the DUT is idle.
    task automatic applyStimulus(input int idx, input logic [FW-1:0] val,
                                 output int k);
        ack_exp_t  a;
        done_exp_t d;
        int        lat;
        k = cyc;
        req_freq[idx*FW +: FW] = val;
        req_valid[idx]         = 1'b1;
        a.idx = idx;
        a.err = (val < MIN_V);
        a.cyc = k + 1;
        ack_q.push_back(a);
        if (!a.err) begin
            lat = LAT;
`ifdef CLKDIV_SCHED_SAME_SKIP_EN
            if (val == model_freq) lat = 2;
`endif
            d.idx = idx;
            d.val = val;
            d.cyc = k + lat;
            done_q.push_back(d);
            model_freq = val;
        end
    endtask

    // Advance one cycle and compare any ack/done against the scoreboard.
    // Requesters drop valid in their ack cycle.
    task automatic tick();
        ack_exp_t  a;
        done_exp_t d;
        @(negedge clk_in);
        if (req_ack != '0) begin
            acks_seen++;
            if (ack_q.size() == 0) begin
                checkOutput("unexpected_ack", FW'(req_ack), '0);
            end else begin
                a = ack_q.pop_front();
                checkOutput("ack_idx", FW'(req_ack), FW'(onehot(a.idx)));
                checkOutput("ack_err", FW'(req_err), a.err ? FW'(onehot(a.idx)) : '0);
                checkOutput("ack_cycle", FW'(cyc), FW'(a.cyc));
            end
            req_valid = req_valid & ~req_ack;
        end else if (req_err != '0) begin
            checkOutput("err_without_ack", FW'(req_err), '0);
        end else if (ack_q.size() != 0 && ack_q[0].cyc < cyc) begin
            a = ack_q.pop_front();
            checkOutput("missing_ack", FW'(req_ack), FW'(onehot(a.idx)));
        end
        if (req_done != '0) begin
            dones_seen++;
            if (done_q.size() == 0) begin
                checkOutput("unexpected_done", FW'(req_done), '0);
            end else begin
                d = done_q.pop_front();
                checkOutput("done_idx", FW'(req_done), FW'(onehot(d.idx)));
                checkOutput("done_cycle", FW'(cyc), FW'(d.cyc));
                checkOutput("done_freq", freq_val, d.val);
            end
        end else if (done_q.size() != 0 && done_q[0].cyc < cyc) begin
            d = done_q.pop_front();
            checkOutput("missing_done", FW'(req_done), FW'(onehot(d.idx)));
        end
    endtask

    task automatic doReset();
        @(negedge clk_in);
        reset = 1'b1;
        req_valid = '0;
        ack_q.delete();
        done_q.delete();
        model_freq = RST_V;
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
    endtask

    // Assert reset in the middle of a cycle and confirm the outputs drop
    // before any clock edge; the aborted request never completes.
    task automatic abortMidCycle(input string tag);
        #2;
        reset = 1'b1;
        #1;
        checkOutput({tag, "_freq"}, freq_val, RST_V);
        checkOutput({tag, "_busy"}, FW'(busy), '0);
        checkOutput({tag, "_div_reset"}, FW'(div_reset), '0);
        checkOutput({tag, "_done"}, FW'(req_done), '0);
        done_q.delete();
        req_valid  = '0;
        model_freq = RST_V;
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
    endtask

    logic [FW-1:0] rr_vals [NREQ];

    initial begin
        int k;
        int c;
        ack_exp_t  a;
        done_exp_t d;
        rr_vals = '{32'd4, 32'd6, 32'd8, 32'd12};
        $display("[TB] clkdiv_sched bench starting");
        repeat (3) @(negedge clk_in);
        reset = 1'b0;

        // Idle after reset: nothing moves for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("idle_freq", freq_val, RST_V);
            checkOutput("idle_div_reset", FW'(div_reset), '0);
            checkOutput("idle_busy", FW'(busy), '0);
        end

        // Requester 1, value 10: HOLD/LOAD window, load point, done latency.
        applyStimulus(1, 32'd10, k);
        for (int i = 0; i < 23; i++) begin
            tick();
            c = cyc;
            checkOutput("chg_div_reset", FW'(div_reset), FW'(c >= k + 1 && c <= k + 5));
            checkOutput("chg_freq", freq_val, (c >= k + 6) ? 32'd10 : RST_V);
            checkOutput("chg_busy", FW'(busy), FW'(c >= k + 1 && c <= k + 22));
        end

        // Requester 2, value 1: rejected, FSM stays idle.
        applyStimulus(2, 32'd1, k);
        for (int i = 0; i < 25; i++) begin
            tick();
            checkOutput("rej_busy", FW'(busy), '0);
            checkOutput("rej_freq", freq_val, 32'd10);
            checkOutput("rej_div_reset", FW'(div_reset), '0);
        end

        // Reset in the middle of LOCK.
        applyStimulus(3, 32'd5, k);
        repeat (10) tick();
        checkOutput("lock_phase_div_reset", FW'(div_reset), '0);
        checkOutput("lock_phase_busy", FW'(busy), 32'd1);
        abortMidCycle("rst_lock");
        for (int i = 0; i < 30; i++) begin
            tick();
            checkOutput("post_rst_busy", FW'(busy), '0);
        end

        // Reset during HOLD, then a normal request is served.
        applyStimulus(0, 32'd9, k);
        repeat (2) tick();
        checkOutput("hold_div_reset", FW'(div_reset), 32'd1);
        abortMidCycle("rst_hold");
        repeat (5) tick();
        applyStimulus(3, 32'd7, k);
        repeat (25) tick();
        checkOutput("after_hold_freq", freq_val, 32'd7);

        // Same value as the reset value: skip path when enabled.
        doReset();
        applyStimulus(1, RST_V, k);
        for (int i = 0; i < 24; i++) begin
            tick();
`ifdef CLKDIV_SCHED_SAME_SKIP_EN
            checkOutput("skip_div_reset", FW'(div_reset), '0);
`endif
        end

        // All four requesters continuously valid: grants rotate 0,1,2,3,0.
        doReset();
        acks_seen  = 0;
        dones_seen = 0;
        k = cyc;
        for (int i = 0; i < NREQ; i++) begin
            req_freq[i*FW +: FW] = rr_vals[i];
        end
        req_valid = '1;
        for (int n = 0; n < 5; n++) begin
            a.idx = n % NREQ;
            a.err = 1'b0;
            a.cyc = k + 1 + 23 * n;
            ack_q.push_back(a);
            d.idx = n % NREQ;
            d.val = rr_vals[n % NREQ];
            d.cyc = k + 22 + 23 * n;
            done_q.push_back(d);
        end
        for (int i = 0; i < 120; i++) begin
            tick();
            if (acks_seen >= 5) begin
                req_valid = '0;
            end else begin
                for (int r = 0; r < NREQ; r++) begin
                    if (req_done[r]) req_valid[r] = 1'b1;
                end
            end
        end
        checkOutput("rr_ack_count", FW'(acks_seen), 32'd5);
        checkOutput("rr_done_count", FW'(dones_seen), FW'(acks_seen));
        checkOutput("rr_final_freq", freq_val, rr_vals[0]);

        repeat (5) tick();
        checkOutput("ack_q_empty", FW'(ack_q.size()), '0);
        checkOutput("done_q_empty", FW'(done_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
